// File: rtl/mat_cache_seq.sv
// mat_cache_seq: multi-block WIDTH x WIDTH matrix scratch store with row/diagonal access and a sequential in-place transpose.
// Ports: clock/reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_idx/wr_data command port;
//        rd_valid/rd_data read result (latency 1, held until the next read); busy/done transpose status.
module mat_cache_seq #(
    parameter int WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CACHE_SIZE = 4,
    localparam int ADDR_SIZE = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1,
    localparam int IDX_SIZE = $clog2(WIDTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [ADDR_SIZE-1:0]          cmd_addr,
    input  logic [IDX_SIZE-1:0]           cmd_idx,
    input  logic [WIDTH*DATA_WIDTH-1:0]   wr_data,
    output logic                          rd_valid,
    output logic [WIDTH*DATA_WIDTH-1:0]   rd_data,
    output logic                          busy,
    output logic                          done
);
    localparam logic [2:0] WR_ROW = 3'd1, WR_DIAG = 3'd2, RD_ROW = 3'd3, RD_DIAG = 3'd4, TRANSPOSE = 3'd5, CLEAR = 3'd6;
    localparam logic [IDX_SIZE-1:0] K_LAST = IDX_SIZE'(WIDTH - 2);

    typedef enum logic {IDLE, XPOSE} state_t;

    state_t                        state, state_nx;
    logic [IDX_SIZE-1:0]           k;
    logic [ADDR_SIZE-1:0]          xp_addr;
    logic [DATA_WIDTH-1:0]         mem [CACHE_SIZE][WIDTH][WIDTH];
    logic                          fire, addr_ok, start, rd_fire;
    logic [WIDTH*DATA_WIDTH-1:0]   rd_next;

    assign busy      = state == XPOSE;
    assign cmd_ready = !busy;
    assign fire      = cmd_valid && cmd_ready;
    assign addr_ok   = 32'(cmd_addr) < CACHE_SIZE;
    assign start     = fire && addr_ok && cmd_op == TRANSPOSE;
    assign rd_fire   = fire && addr_ok && (cmd_op == RD_ROW || cmd_op == RD_DIAG);

    always_comb begin
        state_nx = (state == XPOSE) ? ((k == K_LAST) ? IDLE : XPOSE) : (start ? XPOSE : IDLE);
    end

    // Diagonal column wraps by plain IDX_SIZE-bit truncation of i + idx.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < WIDTH; i++)
            rd_next[i*DATA_WIDTH +: DATA_WIDTH] = (cmd_op == RD_DIAG)
                ? mem[cmd_addr][IDX_SIZE'(i)][IDX_SIZE'(i) + cmd_idx]
                : mem[cmd_addr][cmd_idx][IDX_SIZE'(i)];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            xp_addr  <= '0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nx;
            k        <= busy ? k + 1'b1 : '0;
            done     <= busy && k == K_LAST;
            rd_valid <= rd_fire;
            if (start) xp_addr <= cmd_addr;
            if (rd_fire) rd_data <= rd_next;
        end
    end

    // Storage is never reset; a reset edge also suppresses the swap or write of that cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (busy) begin
                for (int j = 1; j < WIDTH; j++)
                    if (IDX_SIZE'(j) > k) begin
                        mem[xp_addr][k][IDX_SIZE'(j)] <= mem[xp_addr][IDX_SIZE'(j)][k];
                        mem[xp_addr][IDX_SIZE'(j)][k] <= mem[xp_addr][k][IDX_SIZE'(j)];
                    end
            end else if (fire && addr_ok) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cmd_op == WR_ROW)
                        mem[cmd_addr][cmd_idx][IDX_SIZE'(i)] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                    if (cmd_op == WR_DIAG)
                        mem[cmd_addr][IDX_SIZE'(i)][IDX_SIZE'(i) + cmd_idx] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                    if (cmd_op == CLEAR)
                        for (int c = 0; c < WIDTH; c++)
                            mem[cmd_addr][IDX_SIZE'(i)][IDX_SIZE'(c)] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mat_cache_seq.sv
// tb_mat_cache_seq: randomized self-checking bench for mat_cache_seq against an array-based matrix model.
module tb_mat_cache_seq;
    localparam int W = 4, DW = 32, CS = 4;
    localparam logic [2:0] NOP = 3'd0, WRR = 3'd1, WRD = 3'd2, RDR = 3'd3, RDD = 3'd4, XP = 3'd5, CLR = 3'd6, RSV = 3'd7;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [1:0]        cmd_addr = '0;
    logic [1:0]        cmd_idx = '0;
    logic [W*DW-1:0]   wr_data = '0;
    logic              rd_valid;
    logic [W*DW-1:0]   rd_data;
    logic              busy;
    logic              done;

    logic [DW-1:0]     m [CS][W][W];
    int                total = 0;
    int                bad = 0;

    mat_cache_seq #(.WIDTH(W), .DATA_WIDTH(DW), .CACHE_SIZE(CS)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_idx(cmd_idx), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    function automatic logic [W*DW-1:0] mread(input logic [2:0] op, input int b, input int idx);
        logic [W*DW-1:0] v;
        for (int i = 0; i < W; i++)
            v[i*DW +: DW] = (op == RDD) ? m[b][i][(i + idx) % W] : m[b][idx][i];
        return v;
    endfunction

    function automatic logic [W*DW-1:0] rvec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W*DW-1:0] pattern_row(input int r);
        logic [W*DW-1:0] v;
        for (int c = 0; c < W; c++) v[c*DW +: DW] = 32'(16 * r + c);
        return v;
    endfunction

    task automatic mapply(input logic [2:0] op, input int b, input int idx, input logic [W*DW-1:0] d);
        for (int i = 0; i < W; i++) begin
            if (op == WRR) m[b][idx][i] = d[i*DW +: DW];
            if (op == WRD) m[b][i][(i + idx) % W] = d[i*DW +: DW];
            if (op == CLR) for (int c = 0; c < W; c++) m[b][i][c] = '0;
        end
    endtask

    // After s completed steps, element (r,c) holds the mirrored value iff min(r,c) < s.
    task automatic mxpose(input int b, input int s);
        logic [DW-1:0] t [W][W];
        for (int r = 0; r < W; r++) for (int c = 0; c < W; c++) t[r][c] = m[b][r][c];
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                if (r < s || c < s) m[b][r][c] = t[c][r];
    endtask

    task automatic send(input logic [2:0] op, input int b, input int idx, input logic [W*DW-1:0] d);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = 2'(b); cmd_idx = 2'(idx); wr_data = d;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        mapply(op, b, idx, d);
    endtask

    task automatic fill(input int b, input bit pat);
        for (int r = 0; r < W; r++) send(WRR, b, r, pat ? pattern_row(r) : rvec());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_row();
        logic [W*DW-1:0] d;
        d = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        send(WRR, 1, 2, d);
        send(RDR, 1, 2, '0);
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL row_rd_valid got=%b want=1", rd_valid); end
        total++; if (rd_data !== d) begin bad++; $display("FAIL row_data got=%h want=%h", rd_data, d); end
        @(posedge clock);
        #1;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL row_rd_valid_drop got=%b want=0", rd_valid); end
        total++; if (rd_data !== d) begin bad++; $display("FAIL row_data_held got=%h want=%h", rd_data, d); end
    endtask

    task automatic test_diag();
        logic [W*DW-1:0] want;
        fill(0, 1'b1);
        send(RDD, 0, 3, '0);
        want = {32'd50, 32'd33, 32'd16, 32'd3};
        total++; if (rd_valid !== 1'b1 || rd_data !== want) begin bad++; $display("FAIL diag_read got=%b/%h want=1/%h", rd_valid, rd_data, want); end
        send(WRD, 0, 1, {32'hD, 32'hC, 32'hB, 32'hA});
        send(RDR, 0, 3, '0);
        want = {32'd51, 32'd50, 32'd49, 32'hD};
        total++; if (rd_data !== want) begin bad++; $display("FAIL diag_write_row got=%h want=%h", rd_data, want); end
        for (int d = 0; d < W; d++) begin
            send(RDD, 0, d, '0);
            total++; if (rd_data !== mread(RDD, 0, d)) begin bad++; $display("FAIL diag_all d=%0d got=%h want=%h", d, rd_data, mread(RDD, 0, d)); end
        end
    endtask

    task automatic test_clear_invalid();
        logic [W*DW-1:0] held;
        fill(3, 1'b0);
        send(CLR, 3, 0, rvec());
        send(RDD, 3, 0, '0);
        total++; if (rd_data !== '0) begin bad++; $display("FAIL clear_read got=%h want=0", rd_data); end
        send(RDR, 0, 1, '0);
        held = mread(RDR, 0, 1);
        total++; if (rd_data !== held) begin bad++; $display("FAIL inv_pre_read got=%h want=%h", rd_data, held); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL inv_ready got=%b want=1", cmd_ready); end
        send(RSV, 0, 1, rvec());
        total++; if (rd_valid !== 1'b0 || rd_data !== held) begin bad++; $display("FAIL op7 got=%b/%h want=0/%h", rd_valid, rd_data, held); end
        send(NOP, 0, 1, rvec());
        total++; if (rd_valid !== 1'b0 || rd_data !== held) begin bad++; $display("FAIL nop got=%b/%h want=0/%h", rd_valid, rd_data, held); end
        for (int r = 0; r < W; r++) begin
            send(RDR, 0, r, '0);
            total++; if (rd_data !== mread(RDR, 0, r)) begin bad++; $display("FAIL inv_unchanged r=%0d got=%h want=%h", r, rd_data, mread(RDR, 0, r)); end
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        int b, idx, sel;
        for (int bb = 0; bb < CS; bb++) send(CLR, bb, 0, '0);
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 19));
            op = (sel < 6) ? WRR : (sel < 11) ? WRD : (sel < 15) ? RDR : (sel < 19) ? RDD : CLR;
            b = int'($urandom_range(0, CS - 1));
            idx = int'($urandom_range(0, W - 1));
            send(op, b, idx, rvec());
            if (op == RDR || op == RDD) begin
                total++; if (rd_valid !== 1'b1 || rd_data !== mread(op, b, idx)) begin bad++; $display("FAIL rand_read n=%0d op=%0d got=%b/%h want=1/%h", n, op, rd_valid, rd_data, mread(op, b, idx)); end
            end else begin
                total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rand_no_valid n=%0d got=%b want=0", n, rd_valid); end
            end
        end
    endtask

    task automatic test_transpose();
        int busy_cnt, done_cnt;
        bit ready_bad;
        busy_cnt = 0; done_cnt = 0; ready_bad = 0;
        fill(2, 1'b1);
        send(XP, 2, 0, '0);
        for (int c = 0; c < 8; c++) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (cmd_ready !== !busy || (done && busy)) ready_bad = 1;
            @(posedge clock);
            #1;
        end
        total++; if (busy_cnt != W - 1) begin bad++; $display("FAIL xp_busy_cycles got=%0d want=%0d", busy_cnt, W - 1); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL xp_done_pulses got=%0d want=1", done_cnt); end
        total++; if (ready_bad) begin bad++; $display("FAIL xp_ready got=inconsistent want=cmd_ready==!busy"); end
        mxpose(2, W - 1);
        send(RDR, 2, 0, '0);
        total++; if (rd_data !== {32'd48, 32'd32, 32'd16, 32'd0}) begin bad++; $display("FAIL xp_row0 got=%h want=%h", rd_data, {32'd48, 32'd32, 32'd16, 32'd0}); end
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < W; r++) begin
                send(RDR, b, r, '0);
                total++; if (rd_data !== mread(RDR, b, r)) begin bad++; $display("FAIL xp_blocks b=%0d r=%0d got=%h want=%h", b, r, rd_data, mread(RDR, b, r)); end
            end
    endtask

    task automatic test_back_pressure();
        int dc, vc;
        bit early;
        dc = -1; vc = -1; early = 0;
        fill(3, 1'b0);
        send(XP, 3, 0, '0);
        cmd_valid = 1'b1; cmd_op = RDR; cmd_addr = 2'd3; cmd_idx = 2'd0;
        for (int c = 0; c < 12; c++) begin
            if (done && dc < 0) dc = c;
            if (rd_valid) begin
                vc = c;
                cmd_valid = 1'b0;
                break;
            end
            @(posedge clock);
            #1;
        end
        cmd_valid = 1'b0;
        total++; if (dc != W - 1) begin bad++; $display("FAIL bp_done_cycle got=%0d want=%0d", dc, W - 1); end
        total++; if (vc != W) begin bad++; $display("FAIL bp_read_cycle got=%0d want=%0d", vc, W); end
        mxpose(3, W - 1);
        total++; if (rd_data !== mread(RDR, 3, 0)) begin bad++; $display("FAIL bp_data got=%h want=%h", rd_data, mread(RDR, 3, 0)); end
    endtask

    task automatic test_reset_mid();
        bit done_seen;
        done_seen = 0;
        fill(1, 1'b0);
        send(XP, 1, 0, '0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy_before got=%b want=1", busy); end
        reset = 1'b1;
        cmd_valid = 1'b1; cmd_op = WRR; cmd_addr = 2'd1; cmd_idx = 2'd0; wr_data = rvec();
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        reset = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_status got=b%b d%b r%b want=b0 d0 r1", busy, done, cmd_ready); end
        total++; if (rd_valid !== 1'b0 || rd_data !== '0) begin bad++; $display("FAIL rm_rd got=%b/%h want=0/0", rd_valid, rd_data); end
        for (int c = 0; c < 5; c++) begin
            if (done) done_seen = 1;
            @(posedge clock);
            #1;
        end
        total++; if (done_seen) begin bad++; $display("FAIL rm_done got=1 want=0"); end
        mxpose(1, 2);
        for (int r = 0; r < W; r++) begin
            send(RDR, 1, r, '0);
            total++; if (rd_data !== mread(RDR, 1, r)) begin bad++; $display("FAIL rm_partial r=%0d got=%h want=%h", r, rd_data, mread(RDR, 1, r)); end
        end
    endtask

    initial begin
        test_reset();
        test_row();
        test_diag();
        test_clear_invalid();
        test_random();
        test_transpose();
        test_back_pressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mat_cache_seq.md
Name: mat_cache_seq

Overview:
Multi-block square-matrix scratch store for the matrix unit. Holds CACHE_SIZE matrices of WIDTH x WIDTH elements. Provides row and wrapped-diagonal read/write through a single valid/ready command port. Performs in-place transpose of one selected block as a multi-cycle sequential swap engine, replacing the all-blocks-every-cycle combinational transpose of the previous generation.

Parameters:
WIDTH, 8, matrix dimension N; must be a power of two, >= 2
DATA_WIDTH, 32, bits per element (raw IEEE-754 single; no arithmetic is performed in the block)
CACHE_SIZE, 4, number of matrix blocks; >= 1
ADDR_SIZE, max(1,$clog2(CACHE_SIZE)), block address width (derived)
IDX_SIZE, $clog2(WIDTH), row/diagonal index width (derived)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  3  0 NOP, 1 WR_ROW, 2 WR_DIAG, 3 RD_ROW, 4 RD_DIAG, 5 TRANSPOSE, 6 CLEAR, 7 reserved
cmd_addr  in  ADDR_SIZE  target block
cmd_idx  in  IDX_SIZE  row number or diagonal number
wr_data  in  WIDTH*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
rd_valid  out  1  rd_data valid this cycle
rd_data  out  WIDTH*DATA_WIDTH  read result, same lane layout
busy  out  1  transpose in progress
done  out  1  one-cycle pulse: transpose complete

Behaviour:
- Handshake: command fires on rising edge when cmd_valid && cmd_ready. cmd_ready = !busy. No other source of back-pressure.
- Element M[b][r][c] = row r, column c of block b.
- Row r: lane i <-> M[b][r][i].
- Diagonal d: lane i <-> M[b][i][(i+d) mod WIDTH]. Wrap is natural IDX_SIZE-bit truncation.
- WR_ROW / WR_DIAG: all WIDTH elements written on the firing edge. No byte or lane enables.
- RD_ROW / RD_DIAG: latency 1.
  - rd_valid high for exactly the cycle after the firing edge.
  - rd_data holds the result that cycle and is held (not cleared) afterwards until the next read.
  - A read fired the cycle after a write to the same block returns the new data.
- CLEAR: zeroes all elements of block cmd_addr on the firing edge. Single cycle; busy stays low.
- NOP, op 7, and ops with cmd_addr >= CACHE_SIZE: accepted, no state change, no rd_valid.
- Memory contents are not affected by reset. After power-up, contents are undefined until written or CLEARed.
- TRANSPOSE state machine, states IDLE and XPOSE, counter k (IDX_SIZE bits):
  - IDLE, TRANSPOSE fires: latch cmd_addr into xp_addr, k <= 0, enter XPOSE; busy = 1 from the next cycle.
  - XPOSE, each edge: for all j > k, swap M[xp_addr][k][j] and M[xp_addr][j][k]; k <= k+1.
  - When the swap with k == WIDTH-2 executes: return to IDLE and assert done for the following cycle. In that same cycle busy = 0 and cmd_ready = 1.
  - Total busy cycles = WIDTH-1. A command can fire in the done cycle.
  - Other blocks are untouched. No commands are accepted during XPOSE.
- Reset (any state): next cycle state = IDLE, busy = 0, done = 0, rd_valid = 0, rd_data = 0, k = 0.
  - Reset mid-transpose aborts. The block stays partially transposed (rows < k swapped); no done pulse.
  - A command presented in a reset cycle is ignored.
- Reset values of outputs: cmd_ready = 1, rd_valid = 0, rd_data = 0, busy = 0, done = 0.

Test Plan:
- Row write/read (WIDTH=4, DATA_WIDTH=32): WR_ROW addr1 idx2 lanes {0x3F800000,0x40000000,0x40400000,0x40800000}, then RD_ROW addr1 idx2 -> next cycle rd_valid=1, rd_data equal to the written lanes; rd_valid=0 the cycle after.
- Diagonal mapping: fill block0 with M[r][c] = 16r+c via 4 WR_ROWs; RD_DIAG idx3 -> lanes {3,16,33,50}; WR_DIAG idx1 {0xA,0xB,0xC,0xD} then RD_ROW idx3 -> {0xD,49,50,51}.
- Transpose: block2 filled 16r+c; TRANSPOSE addr2 -> cmd_ready=0/busy=1 for exactly 3 cycles, done pulse once; RD_ROW idx0 -> {0,16,32,48}; block0 and block1 unchanged.
- Back-pressure: hold cmd_valid with RD_ROW during XPOSE -> not accepted until done cycle; fires then, rd_valid the following cycle with transposed data.
- Reset mid-transpose: assert reset at busy cycle 2 -> busy=0, done never pulses, cmd_ready=1; RD_ROW idx0 shows row 0 swapped, row 1 swapped, row 2 col 3 not swapped.
- CLEAR/invalid: CLEAR addr3 then RD_DIAG addr3 idx0 -> all zero; op 7 or NOP accepted with cmd_ready=1, no rd_valid, memory unchanged.
